// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//
// Control side of the execute-stage forwarding muxes. Tracks the destination
// registers of the instructions in EXE and MEM, compares them against the
// decode-stage sources, registers the forwarding select codes for the
// instruction's EXE cycle, stalls the front end on load-use hazards and
// inserts bubbles on stalls and branch flushes.
//
// Parameters:
//   REG_W  register index width
//   CNT_W  stall counter width
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   id_valid           ID holds a real instruction
//   id_src1, id_src2   decode-stage source registers
//   id_use_src1        src1 feeds ALU operand A
//   id_use_src2_alu    src2 feeds ALU operand B
//   id_use_src2_st     src2 feeds the store/compare path
//   id_dest            destination register
//   id_wb_en           instruction writes the register file
//   id_mem_r_en        instruction is a load
//   flush              branch taken in EXE; discard the ID instruction
//   sel_A/sel_B/sel_ST registered mux selects: 0 regfile, 1 MEM ALU, 2 WB
//   stall              combinational: freeze PC and IF/ID, bubble into EXE
//   stall_cnt          saturating count of stall cycles
//
// Build option:
//   HAZARD_FORWARDING_EN  defined: forward from MEM/WB, stall only on load-use.
//                         undefined: selects held at 0, stall on any RAW
//                         dependency against EXE or MEM.

module hazard_forward_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2_alu,
    input  logic             id_use_src2_st,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             flush,
    output logic [1:0]       sel_A,
    output logic [1:0]       sel_B,
    output logic [1:0]       sel_ST,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    // Scoreboard entries
    logic [REG_W-1:0] exe_dest_q, exe_dest_d;
    logic             exe_wb_q, exe_wb_d;
    logic             exe_mr_q, exe_mr_d;
    logic [REG_W-1:0] mem_dest_q, mem_dest_d;
    logic             mem_wb_q, mem_wb_d;

    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;
    logic [1:0]       sel_st_q, sel_st_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic s1_exe, s2_exe, s1_mem, s2_mem;
    logic a_exe, b_exe, st_exe, a_mem, b_mem, st_mem;
    logic hazard;
    logic stall_int;
    logic load_id;

    // Register 0 is hard-wired, so it never matches.
    function automatic logic hit(input logic [REG_W-1:0] src,
                                 input logic [REG_W-1:0] dest,
                                 input logic             wb);
        return (src != '0) && wb && (dest == src);
    endfunction

    // Youngest producer (EXE) wins over the older one (MEM).
    function automatic logic [1:0] sel_code(input logic from_exe,
                                            input logic from_mem);
        if (from_exe) begin
            return 2'd1;
        end else if (from_mem) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    always_comb begin
        s1_exe = hit(id_src1, exe_dest_q, exe_wb_q);
        s2_exe = hit(id_src2, exe_dest_q, exe_wb_q);
        s1_mem = hit(id_src1, mem_dest_q, mem_wb_q);
        s2_mem = hit(id_src2, mem_dest_q, mem_wb_q);

        a_exe  = id_use_src1     & s1_exe;
        b_exe  = id_use_src2_alu & s2_exe;
        st_exe = id_use_src2_st  & s2_exe;
        a_mem  = id_use_src1     & s1_mem;
        b_mem  = id_use_src2_alu & s2_mem;
        st_mem = id_use_src2_st  & s2_mem;
    end

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time; one bubble lets it
    // reach MEM, after which the WB path covers it.
    assign hazard = (a_exe | b_exe | st_exe) & exe_mr_q;
`else
    logic unused_exe_mr;
    assign unused_exe_mr = exe_mr_q;
    // Without forwarding, wait until the producer has reached WB, where the
    // register file's write-before-read makes the value visible.
    assign hazard = a_exe | b_exe | st_exe | a_mem | b_mem | st_mem;
`endif

    // Flush overrides stall: the ID instruction is discarded anyway.
    assign stall_int = id_valid & ~flush & hazard;
    assign load_id   = id_valid & ~stall_int & ~flush;

    always_comb begin
        exe_dest_d = '0;
        exe_wb_d   = 1'b0;
        exe_mr_d   = 1'b0;
        if (load_id) begin
            exe_dest_d = id_dest;
            exe_wb_d   = id_wb_en;
            exe_mr_d   = id_mem_r_en;
        end

        mem_dest_d = exe_dest_q;
        mem_wb_d   = exe_wb_q;

        sel_a_d  = 2'd0;
        sel_b_d  = 2'd0;
        sel_st_d = 2'd0;
`ifdef HAZARD_FORWARDING_EN
        if (load_id) begin
            sel_a_d  = sel_code(a_exe, a_mem);
            sel_b_d  = sel_code(b_exe, b_mem);
            sel_st_d = sel_code(st_exe, st_mem);
        end
`endif

        stall_cnt_d = stall_cnt_q;
        if (stall_int && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_dest_q  <= '0;
            exe_wb_q    <= 1'b0;
            exe_mr_q    <= 1'b0;
            mem_dest_q  <= '0;
            mem_wb_q    <= 1'b0;
            sel_a_q     <= 2'd0;
            sel_b_q     <= 2'd0;
            sel_st_q    <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            exe_dest_q  <= exe_dest_d;
            exe_wb_q    <= exe_wb_d;
            exe_mr_q    <= exe_mr_d;
            mem_dest_q  <= mem_dest_d;
            mem_wb_q    <= mem_wb_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            sel_st_q    <= sel_st_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sel_A     = sel_a_q;
    assign sel_B     = sel_b_q;
    assign sel_ST    = sel_st_q;
    assign stall     = stall_int;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit. Each driven cycle pushes the
// hand-computed response expected at that cycle's falling edge; a monitor
// pops and compares at every falling edge.

module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_src1, id_src2, id_dest;
    logic       id_use_src1, id_use_src2_alu, id_use_src2_st;
    logic       id_wb_en, id_mem_r_en, flush;
    logic [1:0] sel_A, sel_B, sel_ST;
    logic       stall;
    logic [3:0] stall_cnt;

    typedef struct {
        logic       st;
        logic [1:0] a, b, s;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rec    = 0;
    int   ecnt;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_W(5), .CNT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_use_src1     (id_use_src1),
        .id_use_src2_alu (id_use_src2_alu),
        .id_use_src2_st  (id_use_src2_st),
        .id_dest         (id_dest),
        .id_wb_en        (id_wb_en),
        .id_mem_r_en     (id_mem_r_en),
        .flush           (flush),
        .sel_A           (sel_A),
        .sel_B           (sel_B),
        .sel_ST          (sel_ST),
        .stall           (stall),
        .stall_cnt       (stall_cnt)
    );

    task automatic chk(input string name, input int idx, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s rec %0d: got %0d expected %0d", name, idx, act, expv);
        end
    endtask

    // Monitor: compares DUT outputs against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",     n_rec, int'(stall),     int'(e.st));
                chk("sel_A",     n_rec, int'(sel_A),     int'(e.a));
                chk("sel_B",     n_rec, int'(sel_B),     int'(e.b));
                chk("sel_ST",    n_rec, int'(sel_ST),    int'(e.s));
                chk("stall_cnt", n_rec, int'(stall_cnt), int'(e.cnt));
                n_rec++;
            end
        end
    end

    // Drive one ID cycle (u = {use_src1, use_src2_alu, use_src2_st}) and
    // queue the response expected at this cycle's falling edge.
    task automatic cyc(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] u, input logic [4:0] d, input logic wb,
                       input logic mr, input logic fl, input logic est,
                       input logic [1:0] ea, input logic [1:0] eb,
                       input logic [1:0] es, input int ec);
        exp_t e;
        id_valid        = v;
        id_src1         = s1;
        id_src2         = s2;
        id_use_src1     = u[2];
        id_use_src2_alu = u[1];
        id_use_src2_st  = u[0];
        id_dest         = d;
        id_wb_en        = wb;
        id_mem_r_en     = mr;
        flush           = fl;
        e.st  = est;
        e.a   = ea;
        e.b   = eb;
        e.s   = es;
        e.cnt = 4'(ec);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [1:0] ea, input logic [1:0] eb,
                       input logic [1:0] es, input int ec);
        cyc(1'b0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, es, ec);
    endtask

    function automatic int sat_inc(input int c);
        return (c < 15) ? c + 1 : 15;
    endfunction

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        nop(0, 0, 0, 0);                          // held in reset
        rst_n = 1'b1;

`ifdef HAZARD_FORWARDING_EN
        // EXE forward: add r3 ; sub r5,r3,r4
        cyc(1, 1, 2, 3'b110, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 4, 3'b110, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(1, 0, 0, 0);
        // WB forward: add r3 ; nop ; sw r3
        cyc(1, 1, 2, 3'b110, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 0, 0);
        cyc(1, 1, 3, 3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 2, 0);
        // Load-use: lw r2 ; add r6,r2,r2
        cyc(1, 1, 0, 3'b100, 2, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 2, 2, 3'b110, 6, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 2, 2, 3'b110, 6, 1, 0, 0, 0, 0, 0, 0, 1);
        nop(2, 2, 0, 1);
        // Flush in the would-be stall cycle; then a reader of r6 sees a bubble in EXE
        cyc(1, 1, 0, 3'b100, 2, 1, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 2, 2, 3'b110, 6, 1, 0, 1, 0, 0, 0, 0, 1);
        cyc(1, 6, 2, 3'b110, 7, 1, 0, 0, 0, 0, 0, 0, 1);
        nop(0, 2, 0, 1);
        // r0 is never forwarded
        cyc(1, 1, 2, 3'b110, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 3'b111, 8, 1, 0, 0, 0, 0, 0, 0, 1);
        nop(0, 0, 0, 1);
        // Back-to-back writers of r4: youngest wins
        cyc(1, 1, 2, 3'b110, 4, 1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 2, 3'b110, 4, 1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 4, 4, 3'b111, 9, 1, 0, 0, 0, 0, 0, 0, 1);
        nop(1, 1, 1, 1);
        // Repeated load-use pairs drive stall_cnt into saturation
        ecnt = 1;
        for (int i = 0; i < 15; i++) begin
            cyc(1, 1, 0, 3'b100, 2, 1, 1, 0, 0, 0, 0, 0, ecnt);
            cyc(1, 2, 2, 3'b110, 6, 1, 0, 0, 1, 0, 0, 0, ecnt);
            ecnt = sat_inc(ecnt);
            cyc(1, 2, 2, 3'b110, 6, 1, 0, 0, 0, 0, 0, 0, ecnt);
            nop(2, 2, 0, ecnt);
        end
        // Reset in the middle of a load-use stall
        cyc(1, 1, 0, 3'b100, 2, 1, 1, 0, 0, 0, 0, 0, 15);
        rst_n = 1'b0;
        cyc(1, 2, 2, 3'b110, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1, 1, 2, 3'b110, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 4, 3'b110, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(1, 0, 0, 0);
`else
        // add r3 ; or r7,r3,r1 -> two stall cycles
        cyc(1, 1, 2, 3'b110, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 1, 3'b110, 7, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 3, 1, 3'b110, 7, 1, 0, 0, 1, 0, 0, 0, 1);
        cyc(1, 3, 1, 3'b110, 7, 1, 0, 0, 0, 0, 0, 0, 2);
        nop(0, 0, 0, 2);
        // add r3 ; nop ; sw r3 -> one stall cycle
        cyc(1, 1, 2, 3'b110, 3, 1, 0, 0, 0, 0, 0, 0, 2);
        nop(0, 0, 0, 2);
        cyc(1, 1, 3, 3'b101, 0, 0, 0, 0, 1, 0, 0, 0, 2);
        cyc(1, 1, 3, 3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        nop(0, 0, 0, 3);
        // Flush against a dependent instruction; reader of r6 then finds EXE empty
        cyc(1, 1, 0, 3'b100, 2, 1, 1, 0, 0, 0, 0, 0, 3);
        cyc(1, 2, 2, 3'b110, 6, 1, 0, 1, 0, 0, 0, 0, 3);
        cyc(1, 6, 5, 3'b110, 8, 1, 0, 0, 0, 0, 0, 0, 3);
        nop(0, 0, 0, 3);
        // r0 is never stalled on
        cyc(1, 1, 2, 3'b110, 0, 1, 0, 0, 0, 0, 0, 0, 3);
        cyc(1, 0, 0, 3'b111, 8, 1, 0, 0, 0, 0, 0, 0, 3);
        nop(0, 0, 0, 3);
        // Repeated two-cycle stalls drive stall_cnt into saturation
        ecnt = 3;
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 2, 3'b110, 3, 1, 0, 0, 0, 0, 0, 0, ecnt);
            cyc(1, 3, 1, 3'b110, 7, 1, 0, 0, 1, 0, 0, 0, ecnt);
            ecnt = sat_inc(ecnt);
            cyc(1, 3, 1, 3'b110, 7, 1, 0, 0, 1, 0, 0, 0, ecnt);
            ecnt = sat_inc(ecnt);
            cyc(1, 3, 1, 3'b110, 7, 1, 0, 0, 0, 0, 0, 0, ecnt);
            nop(0, 0, 0, ecnt);
        end
        // Reset in the middle of a stall
        cyc(1, 1, 2, 3'b110, 3, 1, 0, 0, 0, 0, 0, 0, 15);
        rst_n = 1'b0;
        cyc(1, 3, 1, 3'b110, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1, 3, 1, 3'b110, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 7, 0, 3'b100, 9, 1, 0, 0, 1, 0, 0, 0, 0);
        nop(0, 0, 0, 1);
`endif

        for (int k = 0; k < 5 && q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
